oneshot_sched: RTL and testbench
================================

ONESHOT_SCHED -- requirements
Module: oneshot_sched

Interface
- REQ-001 SHALL: parameter N_REQ, default 4, number of requesters sharing one 555 one-shot instance.
- REQ-002 SHALL: parameter CNT_W, default 16, width-counter bits.
- REQ-003 SHALL: parameter TRIG_CYCLES, default 4, cycles trig is held low per firing.
- REQ-004 SHALL: parameter RECOVER_CYCLES, default 8, cycles timer reset is held low after each firing (discharge settle).
- REQ-005 SHALL: parameter TIMEOUT_CYCLES, default 1000, watchdog limit (used only with ONESHOT_TIMEOUT_EN).
- REQ-006 SHALL: clk  input  1  single clock, all logic rising-edge.
- REQ-007 SHALL: rst_n  input  1  synchronous active-low reset.
- REQ-008 SHALL: req  input  N_REQ  level request per requester, held until serviced.
- REQ-009 SHALL: grant  output  N_REQ  one-hot owner of current firing, all-zero when idle.
- REQ-010 SHALL: busy  output  1  high in any state but IDLE.
- REQ-011 SHALL: done  output  1  one-cycle completion pulse.
- REQ-012 SHALL: done_id  output  $clog2(N_REQ)  requester index completed, valid with done.
- REQ-013 SHALL: width  output  CNT_W  measured out-high duration in clk cycles, valid with done.
- REQ-014 SHALL: err  output  1  timeout flag, valid with done.
- REQ-015 SHALL: tmr_trig_n  output  1  drives timer trig pin, active-low.
- REQ-016 SHALL: tmr_reset_n  output  1  drives timer reset pin, active-low.
- REQ-017 SHALL: tmr_out  input  1  timer out pin, asynchronous to clk.

Function
- REQ-018 SHALL: tmr_out pass through a two-flop synchronizer; all FSM decisions use synchronized value out_s.
- REQ-019 SHALL: FSM states IDLE, TRIG, WAIT_RISE, MEASURE, RECOVER.
- REQ-020 SHALL: IDLE with any req bit set -> latch round-robin winner (search starts at last_id+1, wraps at N_REQ-1 -> 0), assert grant next cycle, enter TRIG.
- REQ-021 SHALL: TRIG drives tmr_trig_n=0 for exactly TRIG_CYCLES cycles, then WAIT_RISE with tmr_trig_n=1.
- REQ-022 SHALL: WAIT_RISE -> MEASURE on first cycle out_s=1; width counter cleared to 1 on entry.
- REQ-023 SHALL: MEASURE increments counter each cycle out_s=1, saturating at 2^CNT_W-1 (no wrap).
- REQ-024 SHALL: MEASURE on out_s=0 -> done=1 one cycle, width=counter, err=0, done_id=winner, enter RECOVER.
- REQ-025 SHALL: RECOVER drives tmr_reset_n=0 for RECOVER_CYCLES cycles, grant held, then IDLE with grant=0, last_id=winner.
- REQ-026 SHALL: req deasserted by owner mid-firing not abort; firing completes and done issued.
- REQ-027 SHALL: new or simultaneous req bits during non-IDLE states wait; at most one firing in flight.
- REQ-028 SHALL: grant, done_id, width stable from grant assertion until return to IDLE (width/done_id from done cycle).

Reset
- REQ-029 SHALL: rst_n=0 at a clk edge force IDLE, grant=0, busy=0, done=0, done_id=0, width=0, err=0, tmr_trig_n=1, tmr_reset_n=0, last_id=N_REQ-1, synchronizer flops=0.
- REQ-030 SHALL: reset mid-firing abandon operation without done pulse; tmr_reset_n returns 1 first cycle after release.

Configuration
- REQ-031 SHALL: macro ONESHOT_TIMEOUT_EN defined -> cycle counter in WAIT_RISE+MEASURE combined; reaching TIMEOUT_CYCLES forces done=1, err=1, width=current counter (0 if still WAIT_RISE), enter RECOVER.
- REQ-032 SHALL: macro undefined -> no watchdog logic, err tied 0, WAIT_RISE/MEASURE wait indefinitely.

Structure
- REQ-033 SHALL: shared package oneshot_pkg holds FSM state enum and default parameter constants.
- REQ-034 SHALL: synchronizer be sub-module oneshot_sync2 (1-bit, two flops, reset to 0).

Verification (N_REQ=4, TRIG_CYCLES=4, RECOVER_CYCLES=8, TIMEOUT_CYCLES=1000)
- REQ-035 SHALL: req=0001, model drives tmr_out high 50 cycles after trig -> tmr_trig_n low 4 cycles, done with done_id=0, width=50, err=0, tmr_reset_n low 8 cycles.
- REQ-036 SHALL: req=1111 held -> grants in order 0001,0010,0100,1000,0001, each with one done.
- REQ-037 SHALL: tmr_out held high 70000 cycles with macro undefined -> width=65535 (saturated), err=0.
- REQ-038 SHALL: macro defined, tmr_out never rises -> done with err=1, width=0 exactly 1000 cycles after leaving TRIG.
- REQ-039 SHALL: rst_n pulsed low during MEASURE -> no done, all outputs at reset values, next req fires normally.
- REQ-040 SHALL: owner drops req during MEASURE, req=0100 arrives -> owner's done issued first, then grant=0100 after RECOVER.

Source files
------------

// File: rtl/oneshot_pkg.sv
// Shared definitions for the 555 one-shot scheduler: FSM state encoding
// and default parameter values.
package oneshot_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_RECOVER   = 3'd4
  } oneshot_state_t;

  localparam int unsigned DEF_N_REQ          = 4;
  localparam int unsigned DEF_CNT_W          = 16;
  localparam int unsigned DEF_TRIG_CYCLES    = 4;
  localparam int unsigned DEF_RECOVER_CYCLES = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/oneshot_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, flops reset to 0.
module oneshot_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the async input through two flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/oneshot_sched.sv
// Round-robin scheduler sharing one 555 one-shot among N_REQ requesters.
// Fires the timer, measures the out-high width in clk cycles and reports it.
// Optional watchdog on WAIT_RISE+MEASURE enabled by defining ONESHOT_TIMEOUT_EN.
module oneshot_sched
  import oneshot_pkg::*;
#(
  parameter int unsigned N_REQ          = DEF_N_REQ,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [CNT_W-1:0]           width,
  output logic                       err,
  output logic                       tmr_trig_n,
  output logic                       tmr_reset_n,
  input  logic                       tmr_out
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  oneshot_state_t   state, state_nxt;
  logic             out_s;
  logic [IDW-1:0]   winner, last_id, pick;
  logic             pick_vld;
  int unsigned      rr_idx;
  logic [31:0]      pcnt;
  logic [CNT_W-1:0] cnt;
  logic             fire_done, fire_err;
  logic [CNT_W-1:0] fire_width;

  oneshot_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tmr_out),
    .q     (out_s)
  );

`ifdef ONESHOT_TIMEOUT_EN
  logic [31:0] wd;

  // watchdog counts every cycle spent in WAIT_RISE or MEASURE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (state == S_WAIT_RISE || state == S_MEASURE) begin
      wd <= wd + 32'd1;
    end else begin
      wd <= '0;
    end
  end
`endif

  // round-robin search starting just after the last serviced requester
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      rr_idx = (32'(last_id) + i) % N_REQ;
      if (!pick_vld && req[rr_idx[IDW-1:0]]) begin
        pick     = rr_idx[IDW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // next-state and completion decode
  always_comb begin
    state_nxt  = state;
    fire_done  = 1'b0;
    fire_err   = 1'b0;
    fire_width = cnt;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE:      if (pick_vld) state_nxt = S_TRIG;
      S_TRIG:      if (pcnt == TRIG_CYCLES - 1) state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: if (out_s) state_nxt = S_MEASURE;
      S_MEASURE: begin
        if (!out_s) begin
          fire_done = 1'b1;
          state_nxt = S_RECOVER;
        end
      end
      S_RECOVER:   if (pcnt == RECOVER_CYCLES - 1) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
`ifdef ONESHOT_TIMEOUT_EN
    // a normal completion in the same cycle takes precedence over the watchdog
    if ((state == S_WAIT_RISE || state == S_MEASURE) && !fire_done &&
        wd == TIMEOUT_CYCLES - 1) begin
      fire_done  = 1'b1;
      fire_err   = 1'b1;
      fire_width = (state == S_MEASURE) ? cnt : '0;
      state_nxt  = S_RECOVER;
    end
`endif
  end

  // state, counters, registered timer pins and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pcnt        <= '0;
      cnt         <= '0;
      winner      <= '0;
      last_id     <= IDW'(N_REQ - 1);
      grant       <= '0;
      done        <= 1'b0;
      done_id     <= '0;
      width       <= '0;
      err         <= 1'b0;
      tmr_trig_n  <= 1'b1;
      tmr_reset_n <= 1'b0;
    end else begin
      state       <= state_nxt;
      pcnt        <= (state_nxt != state) ? '0 : pcnt + 32'd1;
      tmr_trig_n  <= (state_nxt != S_TRIG);
      tmr_reset_n <= (state_nxt != S_RECOVER);
      done        <= fire_done;
      if (fire_done) begin
        width   <= fire_width;
        err     <= fire_err;
        done_id <= winner;
      end
      if (state == S_IDLE && pick_vld) begin
        winner      <= pick;
        grant       <= '0;
        grant[pick] <= 1'b1;
      end
      if (state == S_RECOVER && state_nxt == S_IDLE) begin
        grant   <= '0;
        last_id <= winner;
      end
      if (state == S_WAIT_RISE && out_s) begin
        cnt <= CNT_W'(1);
      end else if (state == S_MEASURE && out_s && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_oneshot_sched.sv
// Directed bench for oneshot_sched with a behavioural 555 model on tmr_out.
module tb_oneshot_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [15:0] width;
  logic        err;
  logic        tmr_trig_n;
  logic        tmr_reset_n;
  logic        tmr_out;

  int unsigned nvec = 0;
  int unsigned nmis = 0;
  int unsigned pulse_len = 10;

  oneshot_sched #(
    .N_REQ          (4),
    .CNT_W          (16),
    .TRIG_CYCLES    (4),
    .RECOVER_CYCLES (8),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .width       (width),
    .err         (err),
    .tmr_trig_n  (tmr_trig_n),
    .tmr_reset_n (tmr_reset_n),
    .tmr_out     (tmr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // timer model: after trig is released, out goes high for pulse_len clk edges
  initial begin
    tmr_out = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (tmr_trig_n === 1'b0) begin
        while (tmr_trig_n !== 1'b1) begin
          @(posedge clk); #2;
        end
        if (pulse_len != 0) begin
          tmr_out = 1'b1;
          repeat (pulse_len) @(posedge clk);
          #2;
          tmr_out = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_grant"},   grant, 0);
    chk({pfx, "_busy"},    busy, 0);
    chk({pfx, "_done"},    done, 0);
    chk({pfx, "_done_id"}, done_id, 0);
    chk({pfx, "_width"},   width, 0);
    chk({pfx, "_err"},     err, 0);
    chk({pfx, "_trig_n"},  tmr_trig_n, 1);
    chk({pfx, "_reset_n"}, tmr_reset_n, 0);
  endtask

  // one complete firing: grant, trig length, result, recover length, release
  task automatic fire(input logic [3:0] eg, input int unsigned eid, input int unsigned ew,
                      input logic ee, input logic drop, input logic [3:0] late);
    int unsigned n;
    logic to;
    n = 0; to = 1'b0;
    while (grant == 4'b0000) begin
      if (n == 40) begin to = 1'b1; break; end
      tick(); n++;
    end
    chk("grant_wait_timeout", to, 0);
    chk("grant", grant, eg);
    chk("busy", busy, 1);
    if (drop) req = 4'b0000;
    n = 0;
    while (tmr_trig_n == 1'b0 && n < 100) begin tick(); n++; end
    chk("trig_len", n, 4);
    n = 0; to = 1'b0;
    while (done !== 1'b1) begin
      if (n == 80000) begin to = 1'b1; break; end
      tick(); n++;
      if (n == 10 && late != 4'b0000) req = late;
    end
    chk("done_wait_timeout", to, 0);
    if (ee) chk("wd_latency", n, 1000);
    chk("done_id", done_id, eid);
    chk("width", width, ew);
    chk("err", err, ee);
    chk("grant_held", grant, eg);
    n = 0;
    while (tmr_reset_n == 1'b0 && n < 100) begin
      n++;
      tick();
      if (n == 1) chk("done_pulse", done, 0);
    end
    chk("recover_len", n, 8);
    chk("grant_clear", grant, 0);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    int unsigned seen;
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_release_reset_n", tmr_reset_n, 1);
    chk("rst_release_busy", busy, 0);

    // round robin with all requesters held
    pulse_len = 10;
    req = 4'b1111;
    fire(4'b0001, 0, 10, 1'b0, 1'b0, 4'b0000);
    fire(4'b0010, 1, 10, 1'b0, 1'b0, 4'b0000);
    fire(4'b0100, 2, 10, 1'b0, 1'b0, 4'b0000);
    fire(4'b1000, 3, 10, 1'b0, 1'b0, 4'b0000);
    fire(4'b0001, 0, 10, 1'b0, 1'b1, 4'b0000);

    // single requester, 50-cycle pulse
    pulse_len = 50;
    req = 4'b0001;
    fire(4'b0001, 0, 50, 1'b0, 1'b1, 4'b0000);

    // owner drops req, requester 2 arrives mid-measure
    pulse_len = 40;
    req = 4'b0001;
    fire(4'b0001, 0, 40, 1'b0, 1'b1, 4'b0100);
    pulse_len = 20;
    fire(4'b0100, 2, 20, 1'b0, 1'b1, 4'b0000);

    // reset during MEASURE
    pulse_len = 50;
    req = 4'b0001;
    repeat (15) tick();
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    req = 4'b0000;
    tick();
    chk_reset_vals("abort");
    rst_n = 1'b1;
    tick();
    chk("abort_release_reset_n", tmr_reset_n, 1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    chk("abort_no_done", seen, 0);
    pulse_len = 30;
    req = 4'b0001;
    fire(4'b0001, 0, 30, 1'b0, 1'b1, 4'b0000);

`ifdef ONESHOT_TIMEOUT_EN
    // timer never rises: watchdog completion
    pulse_len = 0;
    req = 4'b0010;
    fire(4'b0010, 1, 0, 1'b1, 1'b1, 4'b0000);
`else
    // very long pulse saturates the width counter
    pulse_len = 70000;
    req = 4'b0010;
    fire(4'b0010, 1, 65535, 1'b0, 1'b1, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
